// File: rtl/vmove_pipe.sv
// Vector move/merge unit (vmv.v.v, vmv.v.x/i, vmerge.vvm/vxm) at SEW 8/16/32/64,
// followed by an elastic register pipeline that carries the destination address with the data.
module vmove_pipe #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int SEW_WIDTH   = 2,
  parameter int OPSEL_WIDTH = 2,
  parameter int PIPE_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic [DATA_WIDTH-1:0]   in_vec0,
  input  logic [DATA_WIDTH-1:0]   in_vec1,
  input  logic [63:0]             in_scalar,
  input  logic [DATA_WIDTH/8-1:0] in_mask,
  input  logic                    in_vm,
  input  logic [SEW_WIDTH-1:0]    in_sew,
  input  logic [OPSEL_WIDTH-1:0]  in_opsel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_WIDTH-1:0]   out_addr,
  output logic [DATA_WIDTH-1:0]   out_vec,
  output logic                    busy
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int NBW = (NB > 1) ? $clog2(NB) : 1;

  // Handshake: a transfer happens at a rising edge where valid & ready are both high.
  // Producers hold their payload until that edge; ready may depend combinationally on
  // the downstream ready, but valid never depends on ready.

  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_accept;

  // Each result byte picks its element's mask bit and the matching byte of the scalar.
  for (genvar gb = 0; gb < NB; gb++) begin : g_byte
    logic [NBW-1:0] w_eidx;
    logic [2:0]     w_sidx;
    logic           w_m;
    logic [7:0]     w_src;

    assign w_eidx = NBW'(gb) >> in_sew;
    assign w_sidx = 3'(gb) & ~(3'b111 << in_sew);
    assign w_m    = in_vm | in_mask[w_eidx];
    assign w_src  = in_opsel[0] ? in_scalar[{w_sidx, 3'b000} +: 8] : in_vec1[gb*8 +: 8];
    assign w_result[gb*8 +: 8] = (!in_opsel[1] || w_m) ? w_src : in_vec0[gb*8 +: 8];
  end

  logic                  r_valid [PIPE_DEPTH];
  logic [DATA_WIDTH-1:0] r_data  [PIPE_DEPTH];
  logic [ADDR_WIDTH-1:0] r_addr  [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] w_valid;
  logic                  w_load  [PIPE_DEPTH];

  // A stage may load when the consumer is ready or any stage from it to the tail is empty;
  // written flat so there is no combinational loop through the stage chain.
  for (genvar gk = 0; gk < PIPE_DEPTH; gk++) begin : g_stage
    assign w_valid[gk] = r_valid[gk];
    assign w_load[gk]  = out_ready | ~(&w_valid[PIPE_DEPTH-1:gk]);
  end

  assign in_ready = rst & w_load[0];
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        r_valid[k] <= 1'b0;
        r_data[k]  <= '0;
        r_addr[k]  <= '0;
      end
    end else begin
      if (w_load[0]) begin
        r_valid[0] <= w_accept;
        r_data[0]  <= w_accept ? w_result : '0;
        r_addr[0]  <= w_accept ? in_addr : '0;
      end
      // Empty stages always hold zeros, so a plain copy keeps bubbles zeroed downstream.
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        if (w_load[k]) begin
          r_valid[k] <= r_valid[k-1];
          r_data[k]  <= r_data[k-1];
          r_addr[k]  <= r_addr[k-1];
        end
      end
    end
  end

  assign out_valid = r_valid[PIPE_DEPTH-1];
  assign out_vec   = r_data[PIPE_DEPTH-1];
  assign out_addr  = r_addr[PIPE_DEPTH-1];
  assign busy      = |w_valid;

endmodule

// File: doc/vmove_pipe.md
# vmove_pipe

Parametrised vector move/merge unit for the vALU. It implements vmv.v.v, vmv.v.x/i (scalar splat), and vmerge.vvm/vxm per element at SEW 8/16/32/64, through a configurable-depth elastic pipeline. The pipeline uses valid/ready backpressure, so the vALU can stall it without dropping results. Destination address travels alongside the data.

## Interface
- DATA_WIDTH, 64: vector word width; multiple of 64, ≥64
- ADDR_WIDTH, 32: destination address width
- SEW_WIDTH, 2: element-width code width
- OPSEL_WIDTH, 2: operation select width
- PIPE_DEPTH, 4: number of register stages, ≥1
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready at edge
- in_addr  in  ADDR_WIDTH  destination address
- in_vec0  in  DATA_WIDTH  vs2 operand (merge "false" source)
- in_vec1  in  DATA_WIDTH  vs1 operand
- in_scalar  in  64  rs1/imm scalar, already sign-extended
- in_mask  in  DATA_WIDTH/8  v0 mask bits, bit i → element i
- in_vm  in  1  1 = unmasked (all mask bits treated as 1)
- in_sew  in  SEW_WIDTH  0=8, 1=16, 2=32, 3=64 bit elements
- in_opsel  in  OPSEL_WIDTH  0 MV_VV, 1 MV_VX, 2 MERGE_VV, 3 MERGE_VX
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result at edge when out_valid & out_ready
- out_addr  out  ADDR_WIDTH  destination address of result
- out_vec  out  DATA_WIDTH  result word
- busy  out  1  any pipeline stage holds a valid entry

## Operation
- Elements: E = DATA_WIDTH/(8<<in_sew). Element i occupies bits [i·W +: W], with W = 8<<in_sew. Only mask bits [E-1:0] are used; higher bits are ignored.
- Scalar element: S = in_scalar[W-1:0], truncated.
- Effective mask: m[i] = in_vm | in_mask[i].
- MV_VV: out element i = in_vec1 element i. Mask is ignored.
- MV_VX: every element = S. Mask is ignored.
- MERGE_VV: element i = m[i] ? in_vec1[i] : in_vec0[i].
- MERGE_VX: element i = m[i] ? S : in_vec0[i].
- The result is computed combinationally from inputs and captured into stage 0 on accept. Stages 1..PIPE_DEPTH-1 are pure delay. The last stage drives the outputs.
- Stage k loads from stage k-1 (stage 0 loads from inputs) when stage k is empty or stage k is being drained. Stage k is drained when its successor loads it, or, for the last stage, when out_ready is high.
- in_ready = stage 0 is empty or stage 0 is being drained. This is a combinational chain from out_ready, with no extra bubble.
- A stage that becomes empty loads all-zero data and address. out_vec and out_addr are therefore 0 whenever out_valid = 0.
- busy = OR of all stage valid bits.

## Timing
- Reset (rst low, asynchronous) clears all stage valid, data and addr immediately. Outputs: out_valid=0, out_vec=0, out_addr=0, busy=0.
- in_ready is forced to 0 while rst is low.
- Reset mid-operation discards all in-flight entries. No output appears for them.
- Latency: a request accepted at edge N produces out_valid=1 after edge N+PIPE_DEPTH-1 when unstalled. With PIPE_DEPTH=4, it is visible in the cycle after edge N+3.
- Throughput: 1 request/cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, out_vec and out_addr hold stable. Bubbles upstream collapse. Once all stages are full, in_ready=0.
- Capacity: exactly PIPE_DEPTH entries are in flight. No entry is lost or duplicated. Ordering is FIFO.
- Simultaneous drain and fill on a full pipe at the same edge: both occur, and in_ready stays 1.
- Inputs are sampled only on accept. Changing inputs while in_ready=0 has no effect.

## Test plan
- Reset: hold rst low, drive in_valid=1 → in_ready=0, out_valid=0, out_vec=0, out_addr=0, busy=0. Assert rst low mid-stream with 3 entries in flight → all outputs 0 immediately, and no stale output after release.
- Splat and truncation: MV_VX, sew=1, in_scalar=0xFFFF_FFFF_FFFF_1234, addr=0x40 → after 4 cycles, out_vec=0x1234123412341234, out_addr=0x40.
- Masked merge: MERGE_VV, sew=0, vm=0, mask=0xA5, vec0=0x0, vec1=0x1122334455667788 → out_vec=0x1100330000660088.
- vm override and upper mask bits: MERGE_VX, sew=3, vm=1, mask=0x00, scalar=0x7 → out_vec=0x7. Then vm=0, mask=0xFE → out_vec=in_vec0.
- Backpressure: stream 8 requests with addr 0..7, holding out_ready=0 from cycle 2 to cycle 10 → in_ready falls after 4 entries accepted. Output holds stable during the stall. All 8 results then emerge in order with no gaps once out_ready=1.
- Randomised: random opsel/sew/mask/ready for 10k requests against a reference model → exact order and value match, and out_vec=0 whenever out_valid=0.
